instr_fetch_unit: RTL

Fetch sequencer directly downstream of the N-bit program counter. It takes the counter's current value as the fetch address and runs a request/acknowledge read from instruction memory. It latches the returned word into an instruction register and hands it to decode over a valid/ready handshake. It closes the loop by driving the counter's increment and load controls: one increment per issued instruction, a load for jumps, and nothing after a halt.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: program-counter feedback, instruction-memory read port and decode handoff.
// The master side is the fetch sequencer; the slave side is counter/memory/decode.
interface instr_fetch_unit_if #(
    parameter int N  = 8,
    parameter int IW = 16
);
    logic [N-1:0]  pc_in;
    logic [N-1:0]  mem_addr;
    logic          mem_req;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic [N-1:0]  PCdata;
    logic          PCload;
    logic          PCinc;
    logic [IW-1:0] ir_out;
    logic          ir_valid;
    logic          ir_ready;
    logic          halted;

    modport master (
        input  pc_in, mem_ack, mem_rdata, ir_ready,
        output mem_addr, mem_req, PCdata, PCload, PCinc, ir_out, ir_valid, halted
    );

    modport slave (
        output pc_in, mem_ack, mem_rdata, ir_ready,
        input  mem_addr, mem_req, PCdata, PCload, PCinc, ir_out, ir_valid, halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: reads the word at pc_in, latches it into the instruction register,
// steps or loads the program counter, and hands ordinary words to decode.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | mem_req held, waiting for mem_ack
// UPDATE | one-cycle PCinc (ordinary) or PCload (JMP) pulse
// ISSUE  | ir_valid high until decode accepts
// HALT   | HALT executed, only reset leaves
module instr_fetch_unit #(
    parameter int n  = 8,
    parameter int IW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam logic [3:0] OP_JMP  = 4'hF;
    localparam logic [3:0] OP_HALT = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_UPDATE,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t        state_q;
    logic          mem_req_q;
    logic [n-1:0]  pc_data_q;
    logic          pc_load_q;
    logic          pc_inc_q;
    logic [IW-1:0] ir_q;
    logic          ir_valid_q;
    logic          halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            pc_data_q  <= '0;
            pc_load_q  <= 1'b0;
            pc_inc_q   <= 1'b0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_inc_q  <= 1'b0;
            pc_load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q   <= S_FETCH;
                    mem_req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        ir_q      <= bus.mem_rdata;
                        mem_req_q <= 1'b0;
                        case (bus.mem_rdata[IW-1 -: 4])
                            OP_HALT: begin
                                state_q   <= S_HALT;
                                halted_q  <= 1'b1;
                                pc_data_q <= '0;
                            end
                            OP_JMP: begin
                                state_q   <= S_UPDATE;
                                pc_data_q <= bus.mem_rdata[n-1:0];
                                pc_load_q <= 1'b1;
                            end
                            default: begin
                                state_q  <= S_UPDATE;
                                pc_inc_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_UPDATE: begin
                    // A jump is consumed here and never reaches decode.
                    if (ir_q[IW-1 -: 4] == OP_JMP) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                    end else begin
                        state_q    <= S_ISSUE;
                        ir_valid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.ir_ready) begin
                        state_q    <= S_FETCH;
                        ir_valid_q <= 1'b0;
                        mem_req_q  <= 1'b1;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // pc_in is held stable by the counter throughout FETCH, so it drives the address directly.
    assign bus.mem_addr = (state_q == S_FETCH) ? bus.pc_in : '0;
    assign bus.mem_req  = mem_req_q;
    assign bus.PCdata   = pc_data_q;
    assign bus.PCload   = pc_load_q;
    assign bus.PCinc    = pc_inc_q;
    assign bus.ir_out   = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = halted_q;
endmodule
